// File: rtl/reset_select_seq_pkg.sv
// Shared definitions for the reset_select_seq switchover sequencer:
// FSM state encoding, source constants and the guard counter width.
package reset_select_seq_pkg;

  // Width of the guard-interval down-counter.
  localparam int CNT_W = 8;

  // Source encodings as seen on the mux select input.
  localparam logic SRC_A = 1'b1;
  localparam logic SRC_B = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_LOAD = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage : reset_select_seq_pkg

// File: rtl/reset_select_seq_if.sv
// Request handshake between a switchover requester (master) and the
// reset_select_seq sequencer (slave).
interface reset_select_seq_if;
  logic REQ_VALID;  // switchover request valid
  logic REQ_SEL;    // requested source, 1 = A, 0 = B
  logic REQ_READY;  // sequencer idle and able to accept
  logic DONE;       // one-cycle completion pulse

  modport master (
    output REQ_VALID,
    output REQ_SEL,
    input  REQ_READY,
    input  DONE
  );

  modport slave (
    input  REQ_VALID,
    input  REQ_SEL,
    output REQ_READY,
    output DONE
  );
endinterface : reset_select_seq_if

// File: rtl/seq_downcounter.sv
// Loadable 8-bit down-counter timing the guard intervals before and after
// the select load. Load wins over decrement; decrement stops at zero.
module seq_downcounter
  import reset_select_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  cnt_t load_val_i,
  input  logic dec_i,
  output logic zero_o
);

  cnt_t count_q;

  // Count register: synchronous reset, load, then saturating decrement.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - cnt_t'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule : seq_downcounter

// File: rtl/reset_select_seq.sv
// Glitch-safe switchover sequencer for a registered two-source reset mux.
// A request for a different source raises GUARD for PRE_CYCLES, pulses
// SELECT_ENABLE for one cycle with the new SELECT, keeps GUARD for
// POST_CYCLES more, then pulses DONE. A request for the source already
// loaded completes immediately with no guard and no load.
// Optional feature macro: RESET_SEQ_COUNT_EN adds a saturating SWITCH_COUNT
// output counting select loads.
module reset_select_seq
  import reset_select_seq_pkg::*;
#(
  parameter int PRE_CYCLES  = 4,  // 1..255
  parameter int POST_CYCLES = 4   // 1..255
) (
  input  logic               CLK,
  input  logic               RST,
  reset_select_seq_if.slave  req,
  output logic               CUR_SEL,
  output logic               SELECT,
  output logic               SELECT_ENABLE,
  output logic               GUARD
`ifdef RESET_SEQ_COUNT_EN
  ,
  output logic [CNT_W-1:0]   SWITCH_COUNT
`endif
);

  localparam cnt_t PRE_LOAD  = cnt_t'(PRE_CYCLES - 1);
  localparam cnt_t POST_LOAD = cnt_t'(POST_CYCLES - 1);

  state_e state_q;
  logic   cur_sel_q;
  logic   target_q;
  logic   select_q;
  logic   sel_en_q;
  logic   guard_q;
  logic   ready_q;
  logic   done_q;

  logic   accept;
  logic   cnt_load;
  cnt_t   cnt_load_val;
  logic   cnt_dec;
  logic   cnt_zero;

  // A request is taken only while REQ_READY is visibly high.
  assign accept = req.REQ_VALID && ready_q;

  // Counter control: arm for PRE on a differing accept, for POST in LOAD.
  // NOTE: every signal gets a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = PRE_LOAD;
    cnt_dec      = 1'b0;
    unique case (state_q)
      S_IDLE: cnt_load = accept && (req.REQ_SEL != cur_sel_q);
      S_LOAD: begin
        cnt_load     = 1'b1;
        cnt_load_val = POST_LOAD;
      end
      S_PRE, S_POST: cnt_dec = 1'b1;
      default: ;
    endcase
  end

  seq_downcounter u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // FSM with registered outputs: each branch sets the outputs that belong
  // to the state being entered, so they line up with state_q.
  // NOTE: sequential state uses non-blocking assignments so every register
  // here sees pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // Force the mux to source B alongside the controller, guard held.
      state_q   <= S_IDLE;
      cur_sel_q <= SRC_B;
      target_q  <= SRC_B;
      select_q  <= SRC_B;
      sel_en_q  <= 1'b1;
      guard_q   <= 1'b1;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      select_q <= cur_sel_q;
      sel_en_q <= 1'b0;
      guard_q  <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            target_q <= req.REQ_SEL;
            if (req.REQ_SEL != cur_sel_q) begin
              state_q <= S_PRE;
              guard_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_PRE: begin
          guard_q <= 1'b1;
          if (cnt_zero) begin
            state_q  <= S_LOAD;
            sel_en_q <= 1'b1;
            select_q <= target_q;
          end
        end
        S_LOAD: begin
          state_q   <= S_POST;
          guard_q   <= 1'b1;
          cur_sel_q <= target_q;
          select_q  <= target_q;
        end
        S_POST: begin
          if (cnt_zero) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            guard_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef RESET_SEQ_COUNT_EN
  logic [CNT_W-1:0] switch_count_q;

  // Saturating count of select loads; same-source requests never load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      switch_count_q <= '0;
    end else if ((state_q == S_LOAD) && (switch_count_q != '1)) begin
      switch_count_q <= switch_count_q + 1'b1;
    end
  end

  assign SWITCH_COUNT = switch_count_q;
`endif

  assign req.REQ_READY = ready_q;
  assign req.DONE      = done_q;
  assign CUR_SEL       = cur_sel_q;
  assign SELECT        = select_q;
  assign SELECT_ENABLE = sel_en_q;
  assign GUARD         = guard_q;

endmodule : reset_select_seq

// File: tb/tb_reset_select_seq.sv
// Self-checking bench for reset_select_seq. Expected waveforms are derived
// from the cycle offsets after an accept; a registered mux model follows
// SELECT/SELECT_ENABLE. SWITCH_COUNT is exercised when RESET_SEQ_COUNT_EN
// is defined.
module tb_reset_select_seq;

  localparam int PRE  = 4;
  localparam int POST = 4;

  logic clk = 1'b0;
  logic rst;
  logic cur_sel, select, select_en, guard;
  logic mux_sel;
`ifdef RESET_SEQ_COUNT_EN
  logic [7:0] switch_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state.
  logic model_cur   = 1'b0;
  int   model_loads = 0;

  reset_select_seq_if ifc ();

  reset_select_seq #(
    .PRE_CYCLES  (PRE),
    .POST_CYCLES (POST)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .req           (ifc.slave),
    .CUR_SEL       (cur_sel),
    .SELECT        (select),
    .SELECT_ENABLE (select_en),
    .GUARD         (guard)
`ifdef RESET_SEQ_COUNT_EN
    ,
    .SWITCH_COUNT  (switch_count)
`endif
  );

  always #5 clk = ~clk;

  // Registered reset mux model: loads SELECT when enabled.
  always @(posedge clk) if (select_en) mux_sel <= select;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Request one switchover from the current negedge and check every cycle
  // until REQ_READY returns. Outputs packed as {guard,se,select,cur,done,ready}.
  task automatic do_seq(input logic sel, input string tag, output int waited);
    logic       old;
    bit         differ;
    int         last;
    logic [5:0] exp_v, got_v;
    waited = 0;
    ifc.REQ_VALID = 1'b1;
    ifc.REQ_SEL   = sel;
    while (ifc.REQ_READY !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (ifc.REQ_READY !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s accept timeout ready=%b", tag, ifc.REQ_READY);
      ifc.REQ_VALID = 1'b0;
      return;
    end
    old    = model_cur;
    differ = (sel != old);
    last   = differ ? PRE + POST + 3 : 2;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == 1) ifc.REQ_VALID = 1'b0;
      if (differ)
        exp_v = {1'(k <= PRE + POST + 1), 1'(k == PRE + 1),
                 (k >= PRE + 1) ? sel : old, (k >= PRE + 2) ? sel : old,
                 1'(k == PRE + POST + 2), 1'(k == PRE + POST + 3)};
      else
        exp_v = {1'b0, 1'b0, old, old, 1'(k == 1), 1'(k == 2)};
      got_v = {guard, select_en, select, cur_sel, ifc.DONE, ifc.REQ_READY};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s k=%0d {guard,se,sel,cur,done,ready} got %b exp %b",
                 tag, k, got_v, exp_v);
      end
    end
    if (differ) begin
      model_cur = sel;
      model_loads++;
      checks++;
      if (mux_sel !== sel) begin
        errors++;
        $display("FAIL %s mux_sel got %b exp %b", tag, mux_sel, sel);
      end
    end
`ifdef RESET_SEQ_COUNT_EN
    checks++;
    if (switch_count !== 8'((model_loads > 255) ? 255 : model_loads)) begin
      errors++;
      $display("FAIL %s switch_count got %0d exp %0d", tag, switch_count,
               (model_loads > 255) ? 255 : model_loads);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.REQ_VALID = 1'b0;
    ifc.REQ_SEL   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({guard, select_en, select, cur_sel, ifc.REQ_READY, ifc.DONE} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_hold {guard,se,sel,cur,ready,done} got %b exp 110000",
               {guard, select_en, select, cur_sel, ifc.REQ_READY, ifc.DONE});
    end
`ifdef RESET_SEQ_COUNT_EN
    checks++;
    if (switch_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count got %0d exp 0", switch_count);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.REQ_READY, guard, select_en, cur_sel} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release {ready,guard,se,cur} got %b exp 1000",
               {ifc.REQ_READY, guard, select_en, cur_sel});
    end
    model_cur   = 1'b0;
    model_loads = 0;
  endtask

  task automatic test_same_source();
    int w;
    do_seq(1'b0, "same_b", w);
  endtask

  task automatic test_switch();
    int w;
    do_seq(1'b1, "switch_b_to_a", w);
    do_seq(1'b1, "same_a", w);
    do_seq(1'b0, "switch_a_to_b", w);
  endtask

  task automatic test_reset_mid_post();
    bit saw_done;
    ifc.REQ_VALID = 1'b1;
    ifc.REQ_SEL   = 1'b1;
    for (int i = 0; i < 100 && ifc.REQ_READY !== 1'b1; i++) @(negedge clk);
    for (int k = 1; k <= PRE + 3; k++) begin
      @(negedge clk);
      if (k == 1) ifc.REQ_VALID = 1'b0;
    end
    // Second POST cycle: guard still high, mux already on A.
    checks++;
    if ({guard, mux_sel, cur_sel} !== 3'b111) begin
      errors++;
      $display("FAIL mid_post_pre {guard,mux,cur} got %b exp 111", {guard, mux_sel, cur_sel});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({guard, select_en, select, cur_sel, ifc.REQ_READY, ifc.DONE} !== 6'b110000) begin
      errors++;
      $display("FAIL mid_post_abort {guard,se,sel,cur,ready,done} got %b exp 110000",
               {guard, select_en, select, cur_sel, ifc.REQ_READY, ifc.DONE});
    end
    @(negedge clk);
    checks++;
    if (mux_sel !== 1'b0) begin
      errors++;
      $display("FAIL mid_post_mux got %b exp 0", mux_sel);
    end
    rst = 1'b0;
    model_cur   = 1'b0;
    model_loads = 0;
    saw_done = 1'b0;
    for (int i = 0; i < PRE + POST + 4; i++) begin
      @(negedge clk);
      if (ifc.DONE === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if ({saw_done, ifc.REQ_READY, guard, cur_sel} !== 4'b0100) begin
      errors++;
      $display("FAIL mid_post_after {saw_done,ready,guard,cur} got %b exp 0100",
               {saw_done, ifc.REQ_READY, guard, cur_sel});
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [1:0] got_v, exp_v;
    ifc.REQ_VALID = 1'b1;
    ifc.REQ_SEL   = 1'b1;
    for (int i = 0; i < 100 && ifc.REQ_READY !== 1'b1; i++) @(negedge clk);
    for (int k = 1; k <= PRE + POST + 3; k++) begin
      @(negedge clk);
      if (k == 1) ifc.REQ_SEL = 1'b0;  // next request held while busy
      got_v = {ifc.DONE, ifc.REQ_READY};
      exp_v = {1'(k == PRE + POST + 2), 1'(k == PRE + POST + 3)};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL busy k=%0d {done,ready} got %b exp %b", k, got_v, exp_v);
      end
    end
    model_cur = 1'b1;
    model_loads++;
    do_seq(1'b0, "busy_second", w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL busy_accept_delay got %0d exp 0", w);
    end
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_seq(1'($urandom_range(0, 1)), "random", w);
    end
  endtask

`ifdef RESET_SEQ_COUNT_EN
  task automatic test_switch_count();
    int w;
    for (int i = 0; i < 300; i++) do_seq(~model_cur, "count", w);
    checks++;
    if (switch_count !== 8'd255) begin
      errors++;
      $display("FAIL count_saturate got %0d exp 255", switch_count);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_cur   = 1'b0;
    model_loads = 0;
    checks++;
    if (switch_count !== 8'd0) begin
      errors++;
      $display("FAIL count_clear got %0d exp 0", switch_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_same_source();
    test_switch();
    test_reset_mid_post();
    test_back_to_back();
    test_random();
`ifdef RESET_SEQ_COUNT_EN
    test_switch_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reset_select_seq
